// File: rtl/mul_share_ctrl_pkg.sv
// Shared types for the FPU multiplier-sharing controller.
// Also used by other FPU resource arbiters.
package fpu_mul_pkg;

    localparam int MUL_W = 32;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_BUSY,
        MS_RESP
    } mul_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester-side handshake bundle of the shared multiplier.
// master = requesters, slave = controller.
interface mul_share_ctrl_if
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH = MUL_W,
    parameter int N_REQ = 2
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [2*WIDTH-1:0]     rsp_y;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y
    );

endinterface

// File: rtl/mul_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first requester after `last`.
// Shared by FPU resource arbiters.
module rr_pick
    import fpu_mul_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % N);
    endfunction

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any_req && req[wrap(int'(last) + k)]) begin
                grant   = wrap(int'(last) + k);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Time-shares one external combinational MUL between N_REQ
// requesters; operands are held MUL_CYCLES cycles before sampling.
module mul_share_ctrl
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH      = MUL_W,
    parameter int N_REQ      = 2,
    parameter int MUL_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_share_ctrl_if.slave    bus,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_y,
    output logic               busy
);

    localparam int IW = idx_w(N_REQ);
    localparam int CW = idx_w(MUL_CYCLES);

    mul_state_t         state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      grant;
    logic               any_req;

    rr_pick #(.N(N_REQ)) u_pick (
        .req     (bus.req_valid),
        .last    (last_q),
        .grant   (grant),
        .any_req (any_req)
    );

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        res_d         = res_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        unique case (state_q)
            MS_IDLE: begin
                if (any_req) begin
                    bus.req_ready[grant] = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant == IW'(i)) begin
                            op_a_d = bus.req_a[i*WIDTH +: WIDTH];
                            op_b_d = bus.req_b[i*WIDTH +: WIDTH];
                        end
                    end
                    owner_d = grant;
                    cnt_d   = CW'(MUL_CYCLES - 1);
                    state_d = MS_BUSY;
                end
            end
            MS_BUSY: begin
                // Product sampled once operands have settled long enough
                if (cnt_q == '0) begin
                    res_d   = mul_y;
                    state_d = MS_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MS_RESP: begin
                bus.rsp_valid[owner_q] = 1'b1;
                if (bus.rsp_ready[owner_q]) begin
                    last_d  = owner_q;
                    state_d = MS_IDLE;
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mul_a     = op_a_q;
    assign mul_b     = op_b_q;
    assign bus.rsp_y = res_q;
    assign busy      = (state_q != MS_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: one instance with MUL_CYCLES=1, one with 3,
// checked each cycle against a transaction-level model.
module tb_mul_share_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rv [2];
    logic [1:0]  rsr [2];
    logic [1:0]  rro [2];
    logic [1:0]  rvo [2];
    logic [31:0] ra [2][2];
    logic [31:0] rb [2][2];
    logic [31:0] mao [2];
    logic [31:0] mbo [2];
    logic [63:0] yo [2];
    logic [63:0] my [2];
    logic        bo [2];

    int total = 0;
    int bad = 0;

    mul_share_ctrl_if #(.WIDTH(32), .N_REQ(2)) if1 ();
    mul_share_ctrl_if #(.WIDTH(32), .N_REQ(2)) if3 ();

    assign if1.req_valid = rv[0];
    assign if1.req_a     = {ra[0][1], ra[0][0]};
    assign if1.req_b     = {rb[0][1], rb[0][0]};
    assign if1.rsp_ready = rsr[0];
    assign rro[0]        = if1.req_ready;
    assign rvo[0]        = if1.rsp_valid;
    assign yo[0]         = if1.rsp_y;

    assign if3.req_valid = rv[1];
    assign if3.req_a     = {ra[1][1], ra[1][0]};
    assign if3.req_b     = {rb[1][1], rb[1][0]};
    assign if3.rsp_ready = rsr[1];
    assign rro[1]        = if3.req_ready;
    assign rvo[1]        = if3.rsp_valid;
    assign yo[1]         = if3.rsp_y;

    // External combinational multipliers
    assign my[0] = {32'b0, mao[0]} * {32'b0, mbo[0]};
    assign my[1] = {32'b0, mao[1]} * {32'b0, mbo[1]};

    mul_share_ctrl #(.WIDTH(32), .N_REQ(2), .MUL_CYCLES(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1),
        .mul_a (mao[0]),
        .mul_b (mbo[0]),
        .mul_y (my[0]),
        .busy  (bo[0])
    );

    mul_share_ctrl #(.WIDTH(32), .N_REQ(2), .MUL_CYCLES(3)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3),
        .mul_a (mao[1]),
        .mul_b (mbo[1]),
        .mul_y (my[1]),
        .busy  (bo[1])
    );

    function automatic int mc(input int j);
        return (j == 0) ? 1 : 3;
    endfunction

    // Two requesters: the one not served last wins if it asks
    function automatic logic rrm(input logic [1:0] v, input logic last);
        return v[~last] ? ~last : last;
    endfunction

    task automatic chk(input string nm, input int j,
                       input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h exp=%h", nm, j, got, exp);
        end
    endtask

    // Transaction model: one outstanding op per instance
    logic        pend [2] = '{1'b0, 1'b0};
    logic        own [2] = '{1'b0, 1'b0};
    logic        last_m [2] = '{1'b1, 1'b1};
    logic [63:0] ey [2] = '{64'd0, 64'd0};
    logic [63:0] eres [2] = '{64'd0, 64'd0};
    logic [31:0] eopa [2] = '{32'd0, 32'd0};
    logic [31:0] eopb [2] = '{32'd0, 32'd0};
    int          issue [2] = '{0, 0};
    int          cyc = 0;

    function automatic logic vis(input int j);
        return pend[j] && (cyc - issue[j] >= mc(j));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                pend[j]   <= 1'b0;
                own[j]    <= 1'b0;
                last_m[j] <= 1'b1;
                eres[j]   <= '0;
                eopa[j]   <= '0;
                eopb[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (vis(j) && rsr[j][own[j]]) begin
                    pend[j]   <= 1'b0;
                    last_m[j] <= own[j];
                end else if (!pend[j] && |rv[j]) begin
                    pend[j]  <= 1'b1;
                    own[j]   <= rrm(rv[j], last_m[j]);
                    eopa[j]  <= ra[j][rrm(rv[j], last_m[j])];
                    eopb[j]  <= rb[j][rrm(rv[j], last_m[j])];
                    ey[j]    <= {32'b0, ra[j][rrm(rv[j], last_m[j])]}
                              * {32'b0, rb[j][rrm(rv[j], last_m[j])]};
                    issue[j] <= cyc + 1;
                end
                if (pend[j] && (cyc + 1 - issue[j] >= mc(j)))
                    eres[j] <= ey[j];
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            chk("req_ready", j, 64'(rro[j]),
                (pend[j] || !(|rv[j])) ? 64'd0
                : 64'(2'b01 << rrm(rv[j], last_m[j])));
            chk("rsp_valid", j, 64'(rvo[j]),
                vis(j) ? 64'(2'b01 << own[j]) : 64'd0);
            chk("busy", j, 64'(bo[j]), 64'(pend[j]));
            chk("mul_a", j, 64'(mao[j]), 64'(eopa[j]));
            chk("mul_b", j, 64'(mbo[j]), 64'(eopb[j]));
            chk("rsp_y", j, yo[j], eres[j]);
        end
    end

    task automatic wait_grant(input int j, input int r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rro[j][r] && n < 20);
        chk("grant", j, 64'(rro[j]), 64'(2'b01 << r));
    endtask

    task automatic do_op(input int j, input int r,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold);
        int n;
        @(posedge clk);
        #1;
        ra[j][r] = a;
        rb[j][r] = b;
        rv[j][r] = 1'b1;
        wait_grant(j, r);
        @(posedge clk);
        #1;
        rv[j][r] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvo[j][r] && n < 50);
        chk("latency", j, 64'(n - 1), 64'(mc(j)));
        chk("lit rsp_valid", j, 64'(rvo[j]), 64'(2'b01 << r));
        chk("lit rsp_y", j, yo[j], exp);
        repeat (hold) begin
            @(negedge clk);
            chk("hold rsp_y", j, yo[j], exp);
            chk("hold req_ready", j, 64'(rro[j]), 64'd0);
            chk("hold rsp_valid", j, 64'(rvo[j]), 64'(2'b01 << r));
        end
        rsr[j][r] = 1'b1;
        @(posedge clk);
        #1;
        rsr[j][r] = 1'b0;
    endtask

    initial begin
        int nr;
        int ng;
        int it;
        logic [1:0] gsel;
        for (int j = 0; j < 2; j++) begin
            rv[j]  = '0;
            rsr[j] = '0;
            for (int r = 0; r < 2; r++) begin
                ra[j][r] = '0;
                rb[j][r] = '0;
            end
        end
        repeat (2) @(negedge clk);
        chk("rst busy", 0, 64'(bo[0]), 64'd0);
        chk("rst rsp_valid", 1, 64'(rvo[1]), 64'd0);
        chk("rst rsp_y", 1, yo[1], 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(0, 0, 32'd1234, 32'd1234, 64'd1522756, 0);
        do_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001, 0);
        do_op(0, 1, 32'd0, 32'hFFFF_FFFF, 64'd0, 0);
        do_op(1, 0, 32'd70000, 32'd80000, 64'd5600000000, 5);

        // Both requesters streaming on u1; last served was 1
        @(posedge clk);
        #1;
        ra[0][0] = 32'd3;
        rb[0][0] = 32'd5;
        ra[0][1] = 32'd9999;
        rb[0][1] = 32'd9999;
        rv[0]    = 2'b11;
        rsr[0]   = 2'b11;
        nr = 0;
        ng = 0;
        it = 0;
        while (nr < 1000 && it < 20000) begin
            @(negedge clk);
            it++;
            gsel = rro[0];
            if (|rvo[0]) begin
                nr++;
                if (nr == 1) begin
                    chk("first rsp", 0, 64'(rvo[0]), 64'd1);
                    chk("first y", 0, yo[0], 64'd15);
                end
                if (nr == 2) begin
                    chk("second rsp", 0, 64'(rvo[0]), 64'd2);
                    chk("second y", 0, yo[0], 64'd99980001);
                end
            end
            if (|gsel && ng < 4)
                chk("order", 0, 64'(gsel), (ng % 2 == 0) ? 64'd1 : 64'd2);
            if (|gsel)
                ng++;
            @(posedge clk);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (gsel[r]) begin
                    ra[0][r] = 32'($urandom_range(9999));
                    rb[0][r] = 32'($urandom_range(9999));
                end
            end
        end
        chk("stream count", 0, 64'(nr), 64'd1000);
        rv[0] = 2'b00;
        repeat (5) @(posedge clk);
        #1 rsr[0] = 2'b00;

        // Abort in the second BUSY cycle of u3
        @(posedge clk);
        #1;
        ra[1][1] = 32'd7;
        rb[1][1] = 32'd8;
        rv[1][1] = 1'b1;
        wait_grant(1, 1);
        @(posedge clk);
        #1 rv[1] = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", 1, 64'(bo[1]), 64'd0);
        chk("abort rsp_valid", 1, 64'(rvo[1]), 64'd0);
        chk("abort mul_a", 1, 64'(mao[1]), 64'd0);
        chk("abort rsp_y", 1, yo[1], 64'd0);
        chk("abort req_ready", 1, 64'(rro[1]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no rsp after rst", 1, 64'(rvo[1]), 64'd0);
        end
        @(posedge clk);
        #1;
        ra[1][0] = 32'd11;
        rb[1][0] = 32'd13;
        rv[1]    = 2'b11;
        @(negedge clk);
        chk("post-rst grant", 1, 64'(rro[1]), 64'd1);
        @(posedge clk);
        #1;
        rv[1]  = 2'b00;
        rsr[1] = 2'b11;
        repeat (8) @(posedge clk);
        #1 rsr[1] = 2'b00;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Round-robin controller that time-shares one combinational 32x32->64 integer MUL between N_REQ requesters in the FPU (mantissa multiply, integer multiply path).
- Registers the winning operands onto the MUL inputs.
- Holds them for a configurable number of cycles, which acts as a multicycle path budget.
- Captures the 64-bit product and returns it to the owning requester under valid/ready handshake.
- The MUL instance sits outside this block; this block drives its inputs and samples its output.

Parameters:
WIDTH, 32, operand width; product width is 2*WIDTH.
N_REQ, 2, number of requesters (>=2).
MUL_CYCLES, 1, cycles operands are held stable before the product is sampled (>=1).

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  reset; one clock, asynchronous assert, active-low.
req_valid  input  N_REQ  per-requester operand valid.
req_ready  output  N_REQ  per-requester accept; at most one bit high.
req_a  input  N_REQ*WIDTH  packed operand A, requester i in slice i.
req_b  input  N_REQ*WIDTH  packed operand B.
rsp_valid  output  N_REQ  product valid for requester i; at most one bit high.
rsp_ready  input  N_REQ  requester i accepts product.
rsp_y  output  2*WIDTH  shared product bus; meaningful only with a rsp_valid bit.
mul_a  output  WIDTH  to MUL a.
mul_b  output  WIDTH  to MUL b.
mul_y  input  2*WIDTH  from MUL y (combinational, unsigned a*b).
busy  output  1  high in BUSY or RESP.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, op_a=op_b=0, res=0, owner=0, cnt=0, last_grant=N_REQ-1. Requester 0 therefore wins the first arbitration.
- Reset outputs: req_ready=0, rsp_valid=0, rsp_y=0, mul_a=mul_b=0, busy=0.
- Reset asserted mid-operation aborts the operation. The in-flight product is lost and no rsp_valid is issued.
- mul_a/mul_b are always driven from op_a/op_b registers, never directly from req ports.
- rsp_y = res at all times.
- FSM IDLE:
  - grant = first i with req_valid[i], searching last_grant+1 .. last_grant+N_REQ modulo N_REQ.
  - req_ready[grant]=1 combinationally; all other bits 0. With no req_valid, req_ready=0.
  - On the handshake edge: op_a<=req_a[grant], op_b<=req_b[grant], owner<=grant, cnt<=MUL_CYCLES-1, state->BUSY.
- FSM BUSY:
  - req_ready=0.
  - If cnt==0: res<=mul_y, state->RESP. Otherwise cnt<=cnt-1.
- FSM RESP:
  - rsp_valid[owner]=1; req_ready=0.
  - On rsp_ready[owner]: last_grant<=owner, state->IDLE.
  - rsp_ready on non-owner bits is ignored.
  - rsp_valid and rsp_y are held unchanged until the handshake (backpressure of unbounded length).
- Latency: rsp_valid rises at handshake edge + MUL_CYCLES.
  - MUL_CYCLES=1 gives 1 cycle of latency.
  - Minimum issue interval is MUL_CYCLES+2 cycles.
- Requester changing req_a/req_b while req_valid is high and not yet granted: the value sampled at the grant edge is used.
- Requester dropping req_valid before the grant is legal; the request is simply skipped.
- Arithmetic: unsigned, full 2*WIDTH product, no truncation or rounding. Correctness of the product is the MUL's responsibility; this block only checks transport of operands and result.
- Fairness: after serving requester k, k has the lowest priority in the next arbitration.

Decomposition:
- Package fpu_mul_pkg holds:
  - typedef enum logic [1:0] {MS_IDLE, MS_BUSY, MS_RESP} mul_state_t
  - localparam MUL_W=32
- Sub-module rr_pick (purely combinational): inputs are the request vector and last_grant; outputs are grant index and any_req. It is reused by later FPU resource arbiters.

Test Plan:
1. Single request, MUL_CYCLES=1: req_valid=01, a=1234, b=1234 -> req_ready=01 for one cycle; rsp_valid=01 one cycle later, rsp_y=1522756; busy high from the edge after the handshake until the rsp handshake.
2. Simultaneous requests after reset: req0 a=3 b=5, req1 a=9999 b=9999 -> req0 served first with rsp_y=15, then req1 with rsp_y=99980001; rsp_valid never targets the wrong requester.
3. Fairness: both req_valid held high for 4 operations -> grant order 0,1,0,1; 1000 random operands (<10000) give zero mismatches versus a reference a*b.
4. Backpressure, MUL_CYCLES=3: hold rsp_ready low for 5 cycles -> rsp_valid and rsp_y stable throughout, req_ready=00 throughout, latency from handshake to rsp_valid exactly 3 cycles.
5. Extreme operands: a=b=32'hFFFF_FFFF -> rsp_y=64'hFFFF_FFFE_0000_0001; a=0, b=32'hFFFF_FFFF -> rsp_y=0.
6. Reset mid-BUSY (MUL_CYCLES=3, rst_n low in 2nd BUSY cycle) -> all outputs return to reset values immediately; no rsp_valid after release; next request granted to requester 0.
